// File: rtl/venue_spot_ctrl.sv
// Venue mode FSM with an N-position tracking spotlight that steps toward the lowest active sensor.
// Optional sensor filtering (2-stage sync + stability check) is enabled by defining TRK_FILTER_EN.
module venue_spot_ctrl #(
  parameter int unsigned NPOS     = 5,
  parameter int unsigned STEP_DIV = 1,
  parameter int unsigned HOME     = NPOS / 2,
  localparam int unsigned PW      = $clog2(NPOS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sys_en,
  input  logic            pm,
  input  logic            mm,
  input  logic            sm,
  input  logic            hm,
  input  logic [NPOS-1:0] trk_n,
  output logic            v,
  output logic            hl,
  output logic [NPOS-1:0] spo,
  output logic [PW-1:0]   pos,
  output logic            moving
);

  localparam int unsigned DW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DW-1:0] DivLast = DW'(STEP_DIV - 1);

  typedef enum logic [2:0] {
    StOff, StTrans, StPlay, StMusic, StSpeaker, StHouse
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   pos_q, pos_d;
  logic [PW-1:0]   tgt_q, tgt_d;
  logic [DW-1:0]   div_q, div_d;
  logic            spot_en;
  logic [NPOS-1:0] trk_src;
  logic            trk_ok;
  logic            hit;
  logic [PW-1:0]   hit_idx;

  // ---------------- sensor source ----------------
`ifdef TRK_FILTER_EN
  logic [NPOS-1:0] sync1_q, sync2_q, hist_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
      hist_q  <= '1;
    end else begin
      sync1_q <= trk_n;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign trk_src = sync2_q;
  assign trk_ok  = (sync2_q == hist_q);
`else
  assign trk_src = trk_n;
  assign trk_ok  = 1'b1;
`endif

  // Lowest-index active (low) sensor wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NPOS - 1; i >= 0; i--) begin
      if (!trk_src[i]) begin
        hit     = 1'b1;
        hit_idx = PW'(i);
      end
    end
  end

  // ---------------- mode FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StOff;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!sys_en) begin
      state_d = StOff;
    end else begin
      case (state_q)
        StOff:     state_d = StTrans;
        StTrans: begin
          case ({pm, mm, sm, hm})
            4'b1000: state_d = StPlay;
            4'b0100: state_d = StMusic;
            4'b0010: state_d = StSpeaker;
            4'b0001: state_d = StHouse;
            default: state_d = StTrans;
          endcase
        end
        StPlay:    if (!pm) state_d = StTrans;
        StMusic:   if (!mm) state_d = StTrans;
        StSpeaker: if (!sm) state_d = StTrans;
        StHouse:   if (!hm) state_d = StTrans;
        default:   state_d = StOff;
      endcase
    end
  end

  always_comb begin
    v       = 1'b0;
    hl      = 1'b0;
    spot_en = 1'b0;
    unique case (state_q)
      StTrans, StHouse:   hl = 1'b1;
      StPlay, StSpeaker: begin
        v       = 1'b1;
        spot_en = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------- spotlight datapath ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q <= PW'(HOME);
      tgt_q <= PW'(HOME);
      div_q <= '0;
    end else begin
      pos_q <= pos_d;
      tgt_q <= tgt_d;
      div_q <= div_d;
    end
  end

  always_comb begin
    pos_d = pos_q;
    tgt_d = tgt_q;
    div_d = div_q;
    // Shutdown parks at once, without taking one more step on the way to OFF.
    if (!spot_en || !sys_en) begin
      pos_d = PW'(HOME);
      tgt_d = PW'(HOME);
      div_d = '0;
    end else begin
      if (pos_q != tgt_q) begin
        if (div_q == DivLast) begin
          div_d = '0;
          pos_d = (pos_q < tgt_q) ? pos_q + PW'(1) : pos_q - PW'(1);
        end else begin
          div_d = div_q + DW'(1);
        end
      end else begin
        div_d = '0;
      end
      if (trk_ok && hit) tgt_d = hit_idx;
    end
  end

  assign pos    = pos_q;
  assign spo    = spot_en ? (NPOS'(1) << pos_q) : '0;
  assign moving = spot_en && (pos_q != tgt_q);

endmodule
